// File: rtl/snake_renderer.sv
// Snake game core: segment shift register, move/collision FSM
// and registered per-pixel colour lookup for a 160x120 cell grid.
module snake_renderer #(
  parameter int          SNAKE_LENGTH   = 20,
  parameter logic [11:0] COL_BACKGROUND = 12'h00F,
  parameter logic [11:0] COL_BODY       = 12'hFF0,
  parameter logic [11:0] COL_HEAD       = 12'h0F0,
  parameter logic [11:0] COL_TARGET     = 12'hF00,
  parameter logic [11:0] COL_DEAD       = 12'h800
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MOVE_TICK,
  input  logic [1:0]  DIRECTION,
  input  logic [7:0]  TARGET_X,
  input  logic [6:0]  TARGET_Y,
  input  logic [9:0]  ADDRH,
  input  logic [8:0]  ADDRV,
  output logic [11:0] COLOUR_OUT,
  output logic        TARGET_REACHED,
  output logic        DEAD
);

  typedef enum logic {S_PLAY, S_DEAD} state_t;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_LEFT  = 2'd3;

  state_t      r_state;
  logic [1:0]  r_dir;
  logic [7:0]  r_seg_x [SNAKE_LENGTH];
  logic [6:0]  r_seg_y [SNAKE_LENGTH];
  logic [11:0] r_colour;
  logic        r_target_reached;

  logic [1:0]  w_dir;
  logic [7:0]  w_nx;
  logic [6:0]  w_ny;
  logic        w_hit;
  logic        w_on_target_next;
  logic [7:0]  w_px;
  logic [6:0]  w_py;
  logic        w_px_head;
  logic        w_px_body;
  logic        w_px_target;

  // Opposite headings differ only in bit 1, so a reverse is dir ^ 2.
  assign w_dir = (DIRECTION == (r_dir ^ 2'd2)) ? r_dir : DIRECTION;

  always_comb begin
    w_nx = r_seg_x[0];
    w_ny = r_seg_y[0];
    unique case (w_dir)
      D_UP:    w_ny = (r_seg_y[0] == 7'd0)   ? 7'd119 : r_seg_y[0] - 7'd1;
      D_DOWN:  w_ny = (r_seg_y[0] >= 7'd119) ? 7'd0   : r_seg_y[0] + 7'd1;
      D_LEFT:  w_nx = (r_seg_x[0] == 8'd0)   ? 8'd159 : r_seg_x[0] - 8'd1;
      D_RIGHT: w_nx = (r_seg_x[0] >= 8'd159) ? 8'd0   : r_seg_x[0] + 8'd1;
      default: ;
    endcase
  end

  // The tail vacates its cell on this move, so it cannot be hit.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < SNAKE_LENGTH - 1; i++) begin
      if (r_seg_x[i] == w_nx && r_seg_y[i] == w_ny) w_hit = 1'b1;
    end
  end

  assign w_on_target_next = (w_nx == TARGET_X) && (w_ny == TARGET_Y);

  assign w_px = ADDRH[9:2];
  assign w_py = ADDRV[8:2];

  assign w_px_head   = (r_seg_x[0] == w_px) && (r_seg_y[0] == w_py);
  assign w_px_target = (TARGET_X == w_px) && (TARGET_Y == w_py);

  always_comb begin
    w_px_body = 1'b0;
    for (int i = 1; i < SNAKE_LENGTH; i++) begin
      if (r_seg_x[i] == w_px && r_seg_y[i] == w_py) w_px_body = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state          <= S_PLAY;
      r_dir            <= D_RIGHT;
      r_colour         <= 12'h000;
      r_target_reached <= 1'b0;
      for (int i = 0; i < SNAKE_LENGTH; i++) begin
        r_seg_x[i] <= 8'(80 - i);
        r_seg_y[i] <= 7'd60;
      end
    end else begin
      r_target_reached <= 1'b0;
      unique case (r_state)
        S_PLAY: begin
          if (MOVE_TICK) begin
            r_dir <= w_dir;
            if (w_hit) begin
              r_state <= S_DEAD;
            end else begin
              for (int i = 1; i < SNAKE_LENGTH; i++) begin
                r_seg_x[i] <= r_seg_x[i-1];
                r_seg_y[i] <= r_seg_y[i-1];
              end
              r_seg_x[0]       <= w_nx;
              r_seg_y[0]       <= w_ny;
              r_target_reached <= w_on_target_next;
            end
          end
          if (w_px_head)        r_colour <= COL_HEAD;
          else if (w_px_body)   r_colour <= COL_BODY;
          else if (w_px_target) r_colour <= COL_TARGET;
          else                  r_colour <= COL_BACKGROUND;
        end
        S_DEAD: begin
          r_colour <= COL_DEAD;
        end
        default: r_state <= S_DEAD;
      endcase
    end
  end

  assign COLOUR_OUT     = r_colour;
  assign TARGET_REACHED = r_target_reached;
  assign DEAD           = (r_state == S_DEAD);

endmodule
